regfile_psr: RTL and testbench
==============================

# regfile_psr

Operand register file and processor status register (PSR) for the 16-bit datapath. It sits directly upstream of the ALU: its two read ports drive the ALU `reg1` and `reg2` operands. It also consumes the ALU's outputs: the write port takes the ALU `result`, and the PSR latches the low five bits of the ALU `flagreg`.

## Interface
- `WIDTH`, 16, data word width in bits.
- `REGBITS`, 4, register address width; depth is `2**REGBITS` (16 registers).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `wr_en`  in  1  register write enable.
- `wr_addr`  in  REGBITS  register to write.
- `wr_data`  in  WIDTH  write data (ALU `result`).
- `rd_addr1`  in  REGBITS  address for read port 1.
- `rd_addr2`  in  REGBITS  address for read port 2.
- `rd_data1`  out  WIDTH  read port 1 data (feeds ALU `reg1`).
- `rd_data2`  out  WIDTH  read port 2 data (feeds ALU `reg2`).
- `flag_en`  in  1  PSR write enable.
- `flags_in`  in  5  ALU `flagreg[4:0]`: bit 0 C, bit 1 L, bit 2 O, bit 3 E, bit 4 N.
- `psr`  out  5  registered flags, same bit order as `flags_in`.

## Operation
- Storage is `2**REGBITS` registers of WIDTH bits each. All registers are writable; none is hardwired to zero.
- Reset:
  - While `reset` is 0 at a rising edge, every register clears to 0 and `psr` clears to 5'b00000.
  - `wr_en` and `flag_en` are ignored in that cycle.
- Write: when `wr_en` is 1 and `reset` is 1 at a rising edge, register `wr_addr` takes `wr_data`. No other register changes.
- PSR: when `flag_en` is 1 and `reset` is 1 at a rising edge, `psr` takes `flags_in`. Otherwise `psr` holds.
  - PSR update is fully independent of `wr_en`. A compare is `flag_en`=1, `wr_en`=0.
- Read: `rd_dataN` is combinational from the register addressed by `rd_addrN`.
- Write-first bypass: if `wr_en`=1 and `wr_addr`==`rd_addrN` in the same cycle, `rd_dataN` equals `wr_data`, not the stored value.
  - This applies to each port independently.
  - If both read addresses match the write address, both ports show `wr_data`.
- Bypass is suppressed while `reset`=0: read ports return stored contents.
- No arithmetic is performed; widths pass through unchanged. `flags_in` carries only the low five bits of the ALU flag bus; the upper flag bits are not stored.

## Timing
- Write latency: one edge. A value written at edge k is readable from storage after edge k.
  - It is also visible combinationally in the cycle before edge k, via the bypass.
- PSR latency: one edge. `psr` shows the new flags immediately after the capturing edge.
- Read latency: zero cycles, combinational. The path from `rd_addr`/`wr_*` to `rd_data` must settle within one cycle so it can feed the ALU in series.
- Outputs after reset:
  - `rd_data1` and `rd_data2` read 0 for every address.
  - `psr` reads 5'b00000.
- Reset asserted mid-operation overrides any simultaneous write or flag capture at that edge. Contents do not depend on the previous state.
- Back-to-back writes to the same address: the last write wins; each write is visible in the cycle it is presented.
- There is no handshake; every enabled write and capture completes in one cycle.

## Test plan
- Reset: hold `reset`=0 for 2 edges after writing random data -> all 16 registers read 0x0000 and `psr`=5'b00000.
- Write/read: write 0xBEEF to r3 and 0x1234 to r12 on consecutive edges, then set `rd_addr1`=3 and `rd_addr2`=12 -> `rd_data1`=0xBEEF and `rd_data2`=0x1234; all other registers still 0.
- Bypass: with r5=0x0001 stored, present `wr_en`=1, `wr_addr`=5, `wr_data`=0x8000 with `rd_addr1`=`rd_addr2`=5 -> both ports show 0x8000 before the edge and after it.
- PSR independence:
  - `flag_en`=1, `flags_in`=5'b11010, `wr_en`=0 -> `psr`=5'b11010 after the edge, registers unchanged.
  - `wr_en`=1, `flag_en`=0 -> `psr` holds 5'b11010.
- Reset override: at one edge assert `reset`=0 with `wr_en`=1 (r7, 0xFFFF) and `flag_en`=1 (5'b11111) -> r7=0x0000, `psr`=5'b00000, and no bypass seen on `rd_data` during that cycle.
- ALU loop: r1=0x7FFF, r2=0x0001. Feed `rd_data1`/`rd_data2` to the ALU with add, writing back to r3 with `flag_en`=1 -> r3=0x8000 and `psr`=5'b10110 (N=1, E=0, O=1, L=1, C=0).

Source files
------------

// File: rtl/regfile_psr.sv
// ---------------------------------------------------------------------------
// regfile_psr: ALU operand register file (2R/1W, write-first) + 5-bit PSR
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_psr #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [REGBITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [REGBITS-1:0] rd_addr1,
  input  logic [REGBITS-1:0] rd_addr2,
  output logic [WIDTH-1:0]   rd_data1,
  output logic [WIDTH-1:0]   rd_data2,
  input  logic               flag_en,
  input  logic [4:0]         flags_in,
  output logic [4:0]         psr
);

  localparam int DEPTH = 2 ** REGBITS;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [4:0]       psr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      psr_q <= '0;
    end else if (flag_en) begin
      psr_q <= flags_in;
    end
  end

  assign psr = psr_q;

  // Bypass is gated by reset so a write being discarded at this edge never
  // appears on the read ports.
  logic bypass1;
  logic bypass2;

  assign bypass1 = reset && wr_en && (wr_addr == rd_addr1);
  assign bypass2 = reset && wr_en && (wr_addr == rd_addr2);

  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (bypass1) begin
      rd_data1 = wr_data;
    end
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (bypass2) begin
      rd_data2 = wr_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_psr.sv
// ---------------------------------------------------------------------------
// tb_regfile_psr: directed + randomized checks against an array-based model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_psr;

  localparam int WIDTH   = 16;
  localparam int REGBITS = 4;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_en;
  logic [REGBITS-1:0] wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [REGBITS-1:0] rd_addr1;
  logic [REGBITS-1:0] rd_addr2;
  logic [WIDTH-1:0]   rd_data1;
  logic [WIDTH-1:0]   rd_data2;
  logic               flag_en;
  logic [4:0]         flags_in;
  logic [4:0]         psr;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [4:0]       psr_m;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  regfile_psr #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .flag_en  (flag_en),
    .flags_in (flags_in),
    .psr      (psr)
  );

  // Expected read value: pending write wins unless reset is asserted.
  function automatic logic [WIDTH-1:0] exp_rd(input logic [REGBITS-1:0] a);
    if (reset && wr_en && wr_addr == a) return wr_data;
    return mem[a];
  endfunction

  // Reference ALU add: returns {N,E,O,L,C, result}.
  function automatic logic [20:0] alu_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic c, l, o, e, n;
    s = {1'b0, a} + {1'b0, b};
    c = s[16];
    l = b < a;
    o = (a[15] == b[15]) && (s[15] != a[15]);
    e = a == b;
    n = $signed(b) < $signed(a);
    return {n, e, o, l, c, s[15:0]};
  endfunction

  // Advance one edge, applying the spec rules to the model, then return to negedge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      psr_m = '0;
    end else begin
      if (wr_en) mem[wr_addr] = wr_data;
      if (flag_en) psr_m = flags_in;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset   = 1'b1;
    wr_en   = 1'b0;
    flag_en = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    reset = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d; flag_en = 1'b0;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) begin
      reset = 1'b1; wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'($urandom);
      flag_en = 1'b1; flags_in = 5'($urandom);
      tick();
    end
    wr_en = 1'b0; flag_en = 1'b0; reset = 1'b0;
    tick();
    tick();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = 4'(i);
      rd_addr2 = 4'(DEPTH - 1 - i);
      #1;
      checks++;
      if (rd_data1 !== 16'h0000 || rd_data2 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_regs addr %0d: got %h/%h expected 0000/0000", i, rd_data1, rd_data2);
      end
    end
    checks++;
    if (psr !== 5'b00000) begin
      errors++;
      $display("FAIL reset_psr: got %b expected 00000", psr);
    end
  endtask

  task automatic test_write_read();
    write_reg(4'd3, 16'hBEEF);
    write_reg(4'd12, 16'h1234);
    rd_addr1 = 4'd3; rd_addr2 = 4'd12;
    #1;
    checks++;
    if (rd_data1 !== 16'hBEEF || rd_data2 !== 16'h1234) begin
      errors++;
      $display("FAIL write_read: got %h/%h expected beef/1234", rd_data1, rd_data2);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3 || i == 12) continue;
      rd_addr1 = 4'(i);
      #1;
      checks++;
      if (rd_data1 !== 16'h0000) begin
        errors++;
        $display("FAIL write_read_other r%0d: got %h expected 0000", i, rd_data1);
      end
    end
  endtask

  task automatic test_bypass();
    write_reg(4'd5, 16'h0001);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h8000;
    rd_addr1 = 4'd5; rd_addr2 = 4'd5;
    #1;
    checks++;
    if (rd_data1 !== 16'h8000 || rd_data2 !== 16'h8000) begin
      errors++;
      $display("FAIL bypass_pre: got %h/%h expected 8000/8000", rd_data1, rd_data2);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data1 !== 16'h8000 || rd_data2 !== 16'h8000) begin
      errors++;
      $display("FAIL bypass_post: got %h/%h expected 8000/8000", rd_data1, rd_data2);
    end
  endtask

  task automatic test_psr_independence();
    idle();
    flag_en = 1'b1; flags_in = 5'b11010;
    wr_addr = 4'd6; wr_data = 16'hDEAD;
    tick();
    flag_en = 1'b0;
    #1;
    checks++;
    if (psr !== 5'b11010) begin
      errors++;
      $display("FAIL psr_capture: got %b expected 11010", psr);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = 4'(i);
      #1;
      checks++;
      if (rd_data1 !== mem[i]) begin
        errors++;
        $display("FAIL psr_regs_unchanged r%0d: got %h expected %h", i, rd_data1, mem[i]);
      end
    end
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hA5A5; flags_in = 5'b00101;
    tick();
    wr_en = 1'b0;
    rd_addr1 = 4'd9;
    #1;
    checks++;
    if (psr !== 5'b11010 || rd_data1 !== 16'hA5A5) begin
      errors++;
      $display("FAIL psr_hold: got psr %b r9 %h expected 11010 a5a5", psr, rd_data1);
    end
  endtask

  task automatic test_reset_override();
    write_reg(4'd7, 16'h1111);
    reset = 1'b0; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hFFFF;
    flag_en = 1'b1; flags_in = 5'b11111;
    rd_addr1 = 4'd7; rd_addr2 = 4'd7;
    #1;
    checks++;
    if (rd_data1 !== 16'h1111 || rd_data2 !== 16'h1111) begin
      errors++;
      $display("FAIL reset_no_bypass: got %h/%h expected 1111/1111", rd_data1, rd_data2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data1 !== 16'h0000 || psr !== 5'b00000) begin
      errors++;
      $display("FAIL reset_override: got r7 %h psr %b expected 0000 00000", rd_data1, psr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    v = 16'h0;
    rd_addr1 = 4'd10; rd_addr2 = 4'd10;
    for (int k = 0; k < 3; k++) begin
      v = 16'($urandom);
      reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd10; wr_data = v;
      #1;
      checks++;
      if (rd_data1 !== v || rd_data2 !== v) begin
        errors++;
        $display("FAIL b2b_bypass %0d: got %h/%h expected %h", k, rd_data1, rd_data2, v);
      end
      tick();
    end
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd_data1 !== v) begin
      errors++;
      $display("FAIL b2b_last_wins: got %h expected %h", rd_data1, v);
    end
  endtask

  task automatic test_alu_loop();
    logic [20:0] r;
    write_reg(4'd1, 16'h7FFF);
    write_reg(4'd2, 16'h0001);
    rd_addr1 = 4'd1; rd_addr2 = 4'd2;
    #1;
    r = alu_add(rd_data1, rd_data2);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = r[15:0];
    flag_en = 1'b1; flags_in = r[20:16];
    tick();
    idle();
    rd_addr1 = 4'd3;
    #1;
    checks++;
    if (rd_data1 !== 16'h8000 || psr !== 5'b10110) begin
      errors++;
      $display("FAIL alu_loop: got r3 %h psr %b expected 8000 10110", rd_data1, psr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 24) != 0);
      wr_en    = 1'($urandom);
      wr_addr  = 4'($urandom);
      wr_data  = 16'($urandom);
      flag_en  = 1'($urandom);
      flags_in = 5'($urandom);
      rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom);
      rd_addr2 = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom);
      #1;
      checks++;
      if (rd_data1 !== exp_rd(rd_addr1) || rd_data2 !== exp_rd(rd_addr2) || psr !== psr_m) begin
        errors++;
        $display("FAIL random %0d: got %h/%h psr %b expected %h/%h psr %b", n,
                 rd_data1, rd_data2, psr, exp_rd(rd_addr1), exp_rd(rd_addr2), psr_m);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    psr_m = '0;
    reset = 1'b0; wr_en = 1'b0; flag_en = 1'b0;
    wr_addr = '0; wr_data = '0; flags_in = '0; rd_addr1 = '0; rd_addr2 = '0;
    @(negedge clk);
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_psr_independence();
    test_reset_override();
    test_back_to_back();
    test_alu_loop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
